// File: rtl/cci_mpf_prim_repl_victim_sel.sv
// Victim-way selector in front of the pseudo-LRU replacement table.
// Takes one fill request at a time, prefers an invalid way, otherwise asks
// the LRU table, hands the victim to the fill pipeline and then reports the
// fill back to the LRU as a reference.
module cci_mpf_prim_repl_victim_sel #(
  parameter int unsigned N_WAYS      = 4,
  parameter int unsigned N_ENTRIES   = 1024,
  parameter int unsigned RSP_TIMEOUT = 7,
  localparam int unsigned IDXW       = $clog2(N_ENTRIES),
  localparam int unsigned WAYW       = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              lruRdy,

  input  logic              reqEn,
  input  logic [IDXW-1:0]   reqIdx,
  input  logic [N_WAYS-1:0] reqValidWays,
  output logic              reqRdy,

  output logic              lookupEn,
  output logic [IDXW-1:0]   lookupIdx,
  input  logic              lookupRspRdy,
  input  logic [N_WAYS-1:0] lookupVecRsp,

  output logic              victimEn,
  output logic [IDXW-1:0]   victimIdx,
  output logic [N_WAYS-1:0] victimVec,
  output logic [WAYW-1:0]   victimWay,
  input  logic              victimDeq,

  output logic              refEn,
  output logic [IDXW-1:0]   refIdx,
  output logic [N_WAYS-1:0] refWayVec,

  output logic              errTimeout
);

  localparam int unsigned CNTW = (RSP_TIMEOUT < 1) ? 1 : $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(RSP_TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // One-hot vector selecting the lowest-numbered invalid way.
  function automatic logic [N_WAYS-1:0] first_invalid(input logic [N_WAYS-1:0] valid);
    logic [N_WAYS-1:0] sel;
    logic              found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (!valid[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return sel;
  endfunction

  // Binary index of a one-hot way vector.
  function automatic logic [WAYW-1:0] way_encode(input logic [N_WAYS-1:0] vec);
    logic [WAYW-1:0] w;
    w = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (vec[i]) begin
        w = w | WAYW'(i);
      end
    end
    return w;
  endfunction

  function automatic logic is_onehot(input logic [N_WAYS-1:0] vec);
    return (vec != '0) && ((vec & (vec - N_WAYS'(1))) == '0);
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              lookup_en_q, lookup_en_d;
  logic [IDXW-1:0]   lookup_idx_q, lookup_idx_d;
  logic              victim_en_q, victim_en_d;
  logic [IDXW-1:0]   victim_idx_q, victim_idx_d;
  logic [N_WAYS-1:0] victim_vec_q, victim_vec_d;
  logic [WAYW-1:0]   victim_way_q, victim_way_d;
  logic              ref_en_q, ref_en_d;
  logic [IDXW-1:0]   ref_idx_q, ref_idx_d;
  logic [N_WAYS-1:0] ref_vec_q, ref_vec_d;
  logic              err_q, err_d;

  logic              req_accept_c;
  logic [CNTW-1:0]   cnt_inc_c;

  // Only combinational output: a new fill may enter when idle and the LRU is up.
  assign reqRdy       = lruRdy && (state_q == S_IDLE);
  assign req_accept_c = reqEn && reqRdy;
  assign cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lookup_en_d  = 1'b0;
    lookup_idx_d = lookup_idx_q;
    victim_en_d  = victim_en_q;
    victim_idx_d = victim_idx_q;
    victim_vec_d = victim_vec_q;
    victim_way_d = victim_way_q;
    ref_en_d     = 1'b0;
    ref_idx_d    = ref_idx_q;
    ref_vec_d    = ref_vec_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_accept_c) begin
          victim_idx_d = reqIdx;
          if (!(&reqValidWays)) begin
            // An empty way needs no LRU consultation.
            victim_vec_d = first_invalid(reqValidWays);
            victim_way_d = way_encode(first_invalid(reqValidWays));
            victim_en_d  = 1'b1;
            state_d      = S_HOLD;
          end else begin
            lookup_en_d  = 1'b1;
            lookup_idx_d = reqIdx;
            state_d      = S_LOOKUP;
          end
        end
      end

      S_LOOKUP: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_inc_c;
        if (lookupRspRdy) begin
          if (is_onehot(lookupVecRsp)) begin
            victim_vec_d = lookupVecRsp;
            victim_way_d = way_encode(lookupVecRsp);
          end else begin
            // Malformed answer: fall back to way 0 and flag it.
            victim_vec_d = N_WAYS'(1);
            victim_way_d = '0;
            err_d        = 1'b1;
          end
          victim_en_d = 1'b1;
          state_d     = S_HOLD;
        end else if (cnt_inc_c == CNT_MAX) begin
          // LRU never answered: fall back to way 0 and flag it.
          victim_vec_d = N_WAYS'(1);
          victim_way_d = '0;
          err_d        = 1'b1;
          victim_en_d  = 1'b1;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (victimDeq) begin
          victim_en_d = 1'b0;
          ref_en_d    = 1'b1;
          ref_idx_d   = victim_idx_q;
          ref_vec_d   = victim_vec_q;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      lookup_en_q  <= 1'b0;
      lookup_idx_q <= '0;
      victim_en_q  <= 1'b0;
      victim_idx_q <= '0;
      victim_vec_q <= '0;
      victim_way_q <= '0;
      ref_en_q     <= 1'b0;
      ref_idx_q    <= '0;
      ref_vec_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      lookup_en_q  <= lookup_en_d;
      lookup_idx_q <= lookup_idx_d;
      victim_en_q  <= victim_en_d;
      victim_idx_q <= victim_idx_d;
      victim_vec_q <= victim_vec_d;
      victim_way_q <= victim_way_d;
      ref_en_q     <= ref_en_d;
      ref_idx_q    <= ref_idx_d;
      ref_vec_q    <= ref_vec_d;
      err_q        <= err_d;
    end
  end

  assign lookupEn   = lookup_en_q;
  assign lookupIdx  = lookup_idx_q;
  assign victimEn   = victim_en_q;
  assign victimIdx  = victim_idx_q;
  assign victimVec  = victim_vec_q;
  assign victimWay  = victim_way_q;
  assign refEn      = ref_en_q;
  assign refIdx     = ref_idx_q;
  assign refWayVec  = ref_vec_q;
  assign errTimeout = err_q;

endmodule
